// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped timer/counter: register offsets,
// CTRL bit positions, MODE encodings and the controller state enum.
package timer_counter_pkg;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_WIDTH   = 4;

  typedef enum logic [1:0] {
    MODE_ONESHOT  = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_RSVD2    = 2'd2,
    MODE_RSVD3    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

endpackage

// File: rtl/timer_counter_if.sv
// CPU data-bus bundle for the timer/counter register window, with
// master (CPU side) and slave (timer side) views.
interface timer_counter_if;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, byteen, wdata, input rdata, irq);
  modport slave  (input addr, byteen, wdata, output rdata, irq);
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot and periodic modes and a
// maskable interrupt; CTRL/PRESET writes are merged per byte lane.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [CTRL_WIDTH-1:0] ctrl;
  logic [31:0]           preset;
  logic [31:0]           count;
  logic                  irq_flag;
  state_e                state;

  logic                  sel;
  logic [1:0]            off;
  logic                  wr_ctrl;
  logic                  wr_preset;
  logic                  wr_any;
  logic [CTRL_WIDTH-1:0] ctrl_merged;
  logic [31:0]           preset_merged;
  mode_e                 mode;
  logic                  unused_addr_bits;

  assign sel       = (addr[31:4] == BASE_ADDR[31:4]);
  assign off       = addr[3:2];
  assign wr_ctrl   = sel && (off == OFF_CTRL)   && (byteen != 4'b0000);
  assign wr_preset = sel && (off == OFF_PRESET) && (byteen != 4'b0000);
  assign wr_any    = wr_ctrl || wr_preset;
  assign mode      = mode_e'(ctrl[CTRL_MODE_HI:CTRL_MODE_LO]);

  // Byte addressing within a word is irrelevant to this word-wide window.
  assign unused_addr_bits = ^addr[1:0];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    preset_merged = preset;
    for (int i = 0; i < 4; i++) begin
      if (byteen[i]) preset_merged[8*i +: 8] = wdata[8*i +: 8];
    end
    ctrl_merged = byteen[0] ? wdata[CTRL_WIDTH-1:0] : ctrl;
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (off)
        OFF_CTRL:   rdata = {{(32-CTRL_WIDTH){1'b0}}, ctrl};
        OFF_PRESET: rdata = preset;
        OFF_COUNT:  rdata = count;
        default:    rdata = '0;
      endcase
    end
  end

  // A CPU write to CTRL/PRESET always wins over the counting sequence: it
  // retires any pending interrupt and parks the controller in IDLE.
  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
      state    <= ST_IDLE;
    end else if (wr_any) begin
      if (wr_ctrl)   ctrl   <= ctrl_merged;
      if (wr_preset) preset <= preset_merged;
      irq_flag <= 1'b0;
      state    <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ctrl[CTRL_EN]) state <= ST_LOAD;
        end
        ST_LOAD: begin
          count <= preset;
          state <= ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl[CTRL_EN]) begin
            state <= ST_IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            // PRESET of 0 or 1 both expire here, one edge after LOAD.
            count    <= '0;
            irq_flag <= 1'b1;
            state    <= ST_INT;
          end
        end
        ST_INT: begin
          if (mode == MODE_PERIODIC) begin
            irq_flag <= 1'b0;
            state    <= ST_LOAD;
          end else begin
            ctrl[CTRL_EN] <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign irq = ctrl[CTRL_IM] & irq_flag;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: a timeline-based reference model is
// compared every cycle, plus directed scenarios with literal expectations.
module tb_timer_counter;

  localparam logic [31:0] BASE  = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL = BASE + 32'h0;
  localparam logic [31:0] A_PRE  = BASE + 32'h4;
  localparam logic [31:0] A_CNT  = BASE + 32'h8;
  localparam logic [31:0] A_RSV  = BASE + 32'hC;
  localparam logic [31:0] A_FAR  = BASE + 32'h20;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   chk_on = 1'b0;

  timer_counter_if bus ();

  timer_counter #(.BASE_ADDR(BASE)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (bus.addr),
    .byteen (bus.byteen),
    .wdata  (bus.wdata),
    .rdata  (bus.rdata),
    .irq    (bus.irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the run is described by the number of edges elapsed
  // since the last (re)start, from which COUNT and the flag are derived.
  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        flag;
    logic        active;
    longint      e;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t step(input mstate_t s, input logic rst, input logic [31:0] a,
                                   input logic [3:0] be, input logic [31:0] wd);
    mstate_t n = s;
    logic [31:0] mask;
    longint np;
    if (rst) begin
      n.ctrl = '0; n.preset = '0; n.count = '0; n.flag = 1'b0; n.active = 1'b0; n.e = 0;
      return n;
    end
    if (a[31:4] == BASE[31:4] && be != 4'b0 && (a[3:2] == 2'd0 || a[3:2] == 2'd1)) begin
      if (a[3:2] == 2'd1) begin
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        n.preset = (s.preset & ~mask) | (wd & mask);
      end else if (be[0]) begin
        n.ctrl = wd[3:0];
      end
      n.flag = 1'b0; n.e = 0; n.active = n.ctrl[0];
      return n;
    end
    if (!s.active) return n;
    np  = (s.preset == 0) ? 1 : longint'(s.preset);
    n.e = s.e + 1;
    if (n.e >= 2 && n.e <= np + 1) begin
      n.count = s.preset - 32'(n.e - 2);
    end else if (n.e == np + 2) begin
      n.count = '0; n.flag = 1'b1;
    end else if (n.e == np + 3) begin
      if (s.ctrl[2:1] == 2'd1) begin
        n.flag = 1'b0; n.e = 1;
      end else begin
        n.ctrl[0] = 1'b0; n.active = 1'b0;
      end
    end
    return n;
  endfunction

  function automatic logic [31:0] mread(input mstate_t s, input logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return '0;
    case (a[3:2])
      2'd0:    return {28'b0, s.ctrl};
      2'd1:    return s.preset;
      2'd2:    return s.count;
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) m <= step(m, reset, bus.addr, bus.byteen, bus.wdata);

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_irq", {31'b0, bus.irq}, {31'b0, m.flag & m.ctrl[3]});
      check("model_rdata", bus.rdata, mread(m, bus.addr));
    end
  end

  task automatic drive(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    @(posedge clk);
    #1;
    bus.addr = a; bus.byteen = be; bus.wdata = wd;
  endtask

  task automatic write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    drive(a, be, wd);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(A_CNT, 4'b0, 32'b0);
  endtask

  task automatic read_expect(input string name, input logic [31:0] a, input logic [31:0] exp);
    drive(a, 4'b0, 32'b0);
    @(negedge clk);
    check(name, bus.rdata, exp);
  endtask

  logic [15:0] pat;
  logic [31:0] c3, c8, c9;
  logic        seen;
  bit          found;

  initial begin
    reset = 1'b1;
    bus.addr = A_CTRL; bus.byteen = 4'b0; bus.wdata = '0;
    repeat (2) @(posedge clk);
    #1 chk_on = 1'b1;

    // Reset state, and reset overriding a simultaneous write.
    write(A_CTRL, 4'hF, 32'h9);
    read_expect("reset_blocks_write", A_CTRL, 32'h0);
    check("reset_irq", {31'b0, bus.irq}, 32'h0);
    reset = 1'b0;
    read_expect("reset_preset", A_PRE, 32'h0);
    read_expect("reset_count", A_CNT, 32'h0);

    // One-shot with interrupt: PRESET=5, CTRL=0x9.
    write(A_PRE, 4'hF, 32'd5);
    write(A_CTRL, 4'hF, 32'h9);
    idle(7);
    @(negedge clk) check("oneshot_irq_before", {31'b0, bus.irq}, 32'h0);
    idle(1);
    @(negedge clk);
    check("oneshot_irq_rise", {31'b0, bus.irq}, 32'h1);
    check("oneshot_count_zero", bus.rdata, 32'h0);
    read_expect("oneshot_en_cleared", A_CTRL, 32'h8);
    idle(3);
    @(negedge clk) check("oneshot_irq_held", {31'b0, bus.irq}, 32'h1);
    write(A_CTRL, 4'hF, 32'h8);
    read_expect("oneshot_ctrl_after", A_CTRL, 32'h8);
    check("oneshot_irq_cleared", {31'b0, bus.irq}, 32'h0);

    // Periodic: PRESET=3, CTRL=0xB -> pulse every 5 cycles.
    write(A_PRE, 4'hF, 32'd3);
    write(A_CTRL, 4'hF, 32'hB);
    pat = '0; c3 = '0; c8 = '0; c9 = '0;
    for (int j = 1; j <= 16; j++) begin
      idle(1);
      @(negedge clk);
      pat[j-1] = bus.irq;
      if (j == 3) c3 = bus.rdata;
      if (j == 8) c8 = bus.rdata;
      if (j == 9) c9 = bus.rdata;
    end
    check("periodic_irq_pattern", {16'b0, pat}, 32'h0000_8420);
    check("periodic_count_first", c3, 32'd3);
    check("periodic_count_reload", c8, 32'd3);
    check("periodic_count_dec", c9, 32'd2);
    write(A_CTRL, 4'hF, 32'h0);

    // Masked one-shot: irq never rises, EN self-clears.
    write(A_PRE, 4'hF, 32'd2);
    write(A_CTRL, 4'hF, 32'h1);
    seen = 1'b0;
    for (int j = 0; j < 10; j++) begin
      idle(1);
      @(negedge clk) seen |= bus.irq;
    end
    check("masked_irq_never", {31'b0, seen}, 32'h0);
    read_expect("masked_count", A_CNT, 32'h0);
    read_expect("masked_ctrl", A_CTRL, 32'h0);

    // Byte-lane merge and ignored writes.
    write(A_PRE, 4'hF, 32'h1234_5678);
    write(A_PRE, 4'b0001, 32'hFFFF_FFFF);
    read_expect("merge_lane0", A_PRE, 32'h1234_56FF);
    write(A_PRE, 4'b1010, 32'hAABB_CCDD);
    read_expect("merge_lanes_1_3", A_PRE, 32'hAA34_CCFF);
    write(A_CNT, 4'hF, 32'hDEAD_BEEF);
    read_expect("count_read_only", A_CNT, 32'h0);
    write(A_FAR, 4'hF, 32'h55);
    read_expect("far_reads_zero", A_FAR, 32'h0);
    read_expect("far_no_effect", A_PRE, 32'hAA34_CCFF);
    write(A_RSV, 4'hF, 32'h77);
    read_expect("rsvd_reads_zero", A_RSV, 32'h0);
    write(A_CTRL, 4'hF, 32'hFFFF_FFF0);
    read_expect("ctrl_high_bits_zero", A_CTRL, 32'h0);

    // Reset in the middle of a long count, with a write on the same edge.
    write(A_PRE, 4'hF, 32'd100);
    write(A_CTRL, 4'hF, 32'h9);
    idle(20);
    write(A_CNT, 4'hF, 32'd7);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      drive(A_CNT, 4'b0, 32'b0);
      @(negedge clk);
      if (bus.rdata == 32'd40) found = 1'b1;
    end
    check("midcount_reached_40", {31'b0, found}, 32'h1);
    #1;
    reset = 1'b1;
    bus.addr = A_CTRL; bus.byteen = 4'hF; bus.wdata = 32'h9;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.byteen = 4'b0;
    @(negedge clk);
    check("midreset_ctrl", bus.rdata, 32'h0);
    check("midreset_irq", {31'b0, bus.irq}, 32'h0);
    read_expect("midreset_preset", A_PRE, 32'h0);
    idle(10);
    read_expect("midreset_no_restart", A_CNT, 32'h0);

    // CTRL write on the CNT->INT edge wins.
    write(A_PRE, 4'hF, 32'd3);
    write(A_CTRL, 4'hF, 32'h9);
    idle(4);
    write(A_CTRL, 4'hF, 32'h8);
    read_expect("race_cnt_ctrl", A_CTRL, 32'h8);
    check("race_cnt_irq", {31'b0, bus.irq}, 32'h0);
    read_expect("race_cnt_count_held", A_CNT, 32'd1);

    // CTRL write while in INT (periodic) wins as well.
    write(A_PRE, 4'hF, 32'd1);
    write(A_CTRL, 4'hF, 32'hB);
    idle(3);
    write(A_CTRL, 4'hF, 32'hA);
    @(negedge clk) check("race_int_irq_before", {31'b0, bus.irq}, 32'h1);
    read_expect("race_int_ctrl", A_CTRL, 32'hA);
    check("race_int_irq_after", {31'b0, bus.irq}, 32'h0);
    idle(6);
    @(negedge clk) check("race_int_stays_idle", bus.rdata, 32'h0);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
